// File: rtl/qpmm_canon_buf_pkg.sv
// BN254 base-field constants shared by the QPMM pipeline and its canonicalising buffer.
package PARAMS_BN254_d0;
  // Two bits of headroom above 256 hold the redundant product range [0, 4*Mod).
  typedef logic [257:0] qpmm_fp_t;

  localparam int FP_W = 256;

  localparam qpmm_fp_t Mod  = qpmm_fp_t'(256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47);
  localparam qpmm_fp_t Mod2 = Mod << 1;
  localparam qpmm_fp_t Mod4 = Mod << 2;
endpackage

// File: rtl/qpmm_canon_buf_if.sv
// Product input, FWFT result output and status bundle of qpmm_canon_buf.
interface qpmm_canon_buf_if #(
  parameter int DEPTH = 8,
  parameter int W     = $bits(PARAMS_BN254_d0::qpmm_fp_t)
);
  logic                         in_valid;
  logic [W-1:0]                 Z;
  logic                         out_valid;
  logic                         out_ready;
  logic [255:0]                 out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic [1:0]                   inflight;
  logic                         overflow;
  logic                         range_err;

  modport master (
    output in_valid, Z, out_ready,
    input  out_valid, out_data, count, inflight, overflow, range_err
  );

  modport slave (
    input  in_valid, Z, out_ready,
    output out_valid, out_data, count, inflight, overflow, range_err
  );
endinterface

// File: rtl/fp_fifo_fwft.sv
// First-word-fall-through FIFO; full/empty come from the occupancy counter, not pointer equality.
module fp_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop;

  assign valid   = (count != '0);
  assign pop     = rd_en && valid;
  // Head is masked while empty so stale storage never shows on the output.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qpmm_canon_buf.sv
// Two-stage conditional subtraction taking Z < 4*Mod to [0, Mod), buffered in a FWFT FIFO.
module qpmm_canon_buf
  import PARAMS_BN254_d0::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = $bits(qpmm_fp_t)
) (
  input logic              clk,
  input logic              rst,
  qpmm_canon_buf_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [W-1:0] M1 = W'(Mod);
  localparam logic [W-1:0] M2 = W'(Mod2);
  localparam logic [W-1:0] M4 = W'(Mod4);

  logic [2:1]      vld_pipe;
  logic [W-1:0]    s1, s1_q;
  logic [FP_W-1:0] s2, s2_q;
  logic [FP_W-1:0] head;
  logic [CW-1:0]   count;
  logic [1:0]      inflight;
  logic            overflow, range_err;
  logic            fifo_valid, full, pop, push;

  assign s1 = (bus.Z >= M2) ? bus.Z - M2 : bus.Z;
  assign s2 = FP_W'((s1_q >= M1) ? s1_q - M1 : s1_q);

  assign full = (count == CW'(DEPTH));
  assign pop  = fifo_valid && bus.out_ready;
  // A full FIFO still takes the result when the head leaves in the same cycle.
  assign push = vld_pipe[2] && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      inflight  <= '0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[1], bus.in_valid};
      s1_q      <= s1;
      s2_q      <= s2;
      inflight  <= 2'(bus.in_valid) + 2'(vld_pipe[1]);
      if (bus.in_valid && bus.Z >= M4)  range_err <= 1'b1;
      if (vld_pipe[2] && full && !pop)  overflow  <= 1'b1;
    end
  end

  fp_fifo_fwft #(.WIDTH(FP_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (s2_q),
    .rd_en   (bus.out_ready),
    .rd_data (head),
    .valid   (fifo_valid),
    .count   (count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = head;
  assign bus.count     = count;
  assign bus.inflight  = inflight;
  assign bus.overflow  = overflow;
  assign bus.range_err = range_err;
endmodule

// File: tb/tb_qpmm_canon_buf.sv
// Directed and streamed checks of qpmm_canon_buf: reduction, latency, back-pressure, flags, reset.
module tb_qpmm_canon_buf;
  import PARAMS_BN254_d0::*;

  localparam int DEPTH   = 8;
  localparam int NSTREAM = 10000;
  localparam int M       = 6;

  logic clk = 1'b0;
  logic rst;

  qpmm_canon_buf_if #(.DEPTH(DEPTH)) bus ();
  qpmm_canon_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    qpmm_fp_t     z;
    logic [255:0] res;
    logic         rerr;
  } vec_t;

  vec_t         tbl[6];
  logic [255:0] exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input qpmm_fp_t z, input logic [255:0] r, input logic e);
    vec_t v;
    v.name = n; v.z = z; v.res = r; v.rerr = e;
    return v;
  endfunction

  function automatic qpmm_fp_t rand_z();
    qpmm_fp_t r = '0;
    for (int i = 0; i < 9; i++) r = {r[225:0], 32'($urandom())};
    return r % Mod4;
  endfunction

  initial begin
    qpmm_fp_t     z, m;
    logic [255:0] want;
    int           nxt;

    tbl[0] = mk("mod_m1",  Mod - 1,  256'(Mod - 1), 1'b0);
    tbl[1] = mk("mod",     Mod,      256'd0,        1'b0);
    tbl[2] = mk("2mod_p5", Mod2 + 5, 256'd5,        1'b0);
    tbl[3] = mk("4mod_m1", Mod4 - 1, 256'(Mod - 1), 1'b0);
    tbl[4] = mk("zero",    '0,       256'd0,        1'b0);
    tbl[5] = mk("4mod",    Mod4,     256'(Mod),     1'b1);

    bus.in_valid = 1'b0; bus.Z = '0; bus.out_ready = 1'b1; rst = 1'b0;
    do_reset();
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_out_data",  bus.out_data,        256'd0);
    chk("rst_count",     256'(bus.count),     256'd0);
    chk("rst_inflight",  256'(bus.inflight),  256'd0);
    chk("rst_overflow",  256'(bus.overflow),  256'd0);
    chk("rst_range_err", 256'(bus.range_err), 256'd0);

    // single values: range flag at t+1, nothing at t+2, result at t+3
    foreach (tbl[i]) begin
      bus.in_valid = 1'b1; bus.Z = tbl[i].z;
      tick();
      bus.in_valid = 1'b0;
      chk({tbl[i].name, "_rerr"},      256'(bus.range_err), 256'(tbl[i].rerr));
      chk({tbl[i].name, "_inflight"},  256'(bus.inflight),  256'd1);
      tick();
      chk({tbl[i].name, "_early"},     256'(bus.out_valid), 256'd0);
      tick();
      chk({tbl[i].name, "_valid"},     256'(bus.out_valid), 256'd1);
      chk({tbl[i].name, "_data"},      bus.out_data,        tbl[i].res);
      tick();
    end

    // back-to-back stream, outputs must be gap-free from the third edge on
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NSTREAM + 3; i++) begin
      if (i < NSTREAM) begin
        z = rand_z();
        m = z % Mod;
        exp_q.push_back(m[255:0]);
        bus.in_valid = 1'b1; bus.Z = z;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= 2 && i <= NSTREAM + 1) begin
        want = exp_q.pop_front();
        chk("stream_valid", 256'(bus.out_valid), 256'd1);
        chk("stream_data",  bus.out_data,        want);
      end
    end
    chk("stream_end_count", 256'(bus.count),     256'd0);
    chk("stream_rerr",      256'(bus.range_err), 256'd0);

    // back-pressure: DEPTH+1 values into a stalled consumer, last one dropped
    do_reset();
    bus.out_ready = 1'b0;
    for (int v = 1; v <= DEPTH + 1; v++) begin
      bus.in_valid = 1'b1; bus.Z = qpmm_fp_t'(v);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_count",    256'(bus.count),    256'(DEPTH));
    chk("bp_overflow", 256'(bus.overflow), 256'd1);
    bus.out_ready = 1'b1;
    for (int v = 1; v <= DEPTH; v++) begin
      chk("bp_drain_valid", 256'(bus.out_valid), 256'd1);
      chk("bp_drain_data",  bus.out_data,        256'(v));
      tick();
    end
    chk("bp_lost", 256'(bus.out_valid), 256'd0);

    // full FIFO with simultaneous pop: push accepted, count held at DEPTH
    do_reset();
    nxt = 1;
    for (int cyc = 1; cyc <= 2 * DEPTH + 12; cyc++) begin
      bus.in_valid  = (cyc <= DEPTH + M);
      bus.Z         = qpmm_fp_t'(cyc);
      bus.out_ready = (cyc >= DEPTH + 3);
      if (cyc >= DEPTH + 3 && cyc <= DEPTH + M + 2)
        chk("fp_count", 256'(bus.count), 256'(DEPTH));
      if (cyc >= DEPTH + 3 && nxt <= DEPTH + M) begin
        chk("fp_valid", 256'(bus.out_valid), 256'd1);
        chk("fp_data",  bus.out_data,        256'(nxt));
        nxt++;
      end
      tick();
    end
    chk("fp_overflow", 256'(bus.overflow), 256'd0);
    chk("fp_drained",  256'(bus.count),    256'd0);
    chk("fp_all_seen", 256'(nxt),          256'(DEPTH + M + 1));

    // mid-stream reset with 3 buffered and 2 in flight
    do_reset();
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      bus.in_valid = 1'b1;
      bus.Z = (v == 1) ? Mod4 : qpmm_fp_t'(10 + v);
      tick();
    end
    chk("mr_pre_count",    256'(bus.count),     256'd3);
    chk("mr_pre_inflight", 256'(bus.inflight),  256'd2);
    chk("mr_pre_rerr",     256'(bus.range_err), 256'd1);
    chk("mr_pre_head",     bus.out_data,        256'(Mod));
    rst = 1'b1; bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mr_count",     256'(bus.count),     256'd0);
    chk("mr_inflight",  256'(bus.inflight),  256'd0);
    chk("mr_out_valid", 256'(bus.out_valid), 256'd0);
    chk("mr_out_data",  bus.out_data,        256'd0);
    chk("mr_rerr",      256'(bus.range_err), 256'd0);
    chk("mr_overflow",  256'(bus.overflow),  256'd0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.Z = Mod2 + 7;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mr_post_early", 256'(bus.out_valid), 256'd0);
    tick();
    chk("mr_post_valid", 256'(bus.out_valid), 256'd1);
    chk("mr_post_data",  bus.out_data,        256'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/qpmm_canon_buf.md
# qpmm_canon_buf

- Downstream stage of the `QPMM_d0_24_16` Montgomery multiplier pipeline.
- Accepts one redundant Montgomery-domain product per cycle (`Z < 4·Mod`) and fully reduces it to the canonical range `[0, Mod)` with a two-stage conditional-subtraction pipeline.
- Buffers results in an output FIFO so a back-pressured consumer can drain them. The multiplier cannot stall, so the block exposes occupancy and sticky error flags to the issuing controller.

## Interface
Parameters:
- `DEPTH`, default 8: output FIFO entries; must be a power of two and ≥ 4.
- `W`, default `$bits(qpmm_fp_t)`: input width.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: `Z` is valid this cycle. Always accepted; there is no ready.
- `Z`  in  `W`: `QPMM_d0_24_16` output, Montgomery domain, contract `Z < 4·Mod`.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: consumer accepts the head.
- `out_data`  out  256: canonical residue, `0 ≤ out_data < Mod`.
- `count`  out  `$clog2(DEPTH+1)`: FIFO occupancy.
- `inflight`  out  2: number of valid entries in S1 and S2.
- `overflow`  out  1: sticky; set when a result is dropped because the FIFO is full.
- `range_err`  out  1: sticky; set when an input violates `Z < 4·Mod`.

## Operation
- S1 (first register stage):
  - If `Z ≥ 2·Mod`, then `s1 = Z − 2·Mod`, else `s1 = Z`.
  - Register `s1` at `W` bits together with `s1_v ← in_valid`.
  - If `in_valid && Z ≥ 4·Mod`, set `range_err`.
- S2 (second register stage):
  - If `s1 ≥ Mod`, then `s2 = s1 − Mod`, else `s2 = s1`.
  - Register `s2` truncated to 256 bits, with `s2_v ← s1_v`.
- Out-of-contract input (`Z ≥ 4·Mod`):
  - It is processed by the same rule, so its output is `Z − 3·Mod` truncated to 256 bits and is not canonical.
  - It is still written to the FIFO.
- FIFO write: when `s2_v` is high, push `s2` at the end of that cycle.
- FIFO read: first-word-fall-through. The head is presented on `out_data` with `out_valid = (count ≠ 0)`. A pop happens on `out_valid && out_ready`.
- Full FIFO:
  - Push with a simultaneous pop: the push is accepted and `count` is unchanged.
  - Push with no pop: the new result is dropped, `overflow` is set, and FIFO contents and `count` are unchanged.
- Empty FIFO: `out_ready` is ignored and there is no underflow.
- Pointer wrap-around: read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Full/empty is decided from `count`, not from pointer equality.
- Flow-control rule for the issuer: issue only while `count + inflight + (QPMM latency) < DEPTH`, or accept `overflow`.
- Sticky flags (`overflow`, `range_err`) clear only on `rst`.

## Timing
- Latency:
  - `Z` sampled at the edge ending cycle t; S1 valid in t+1; S2 valid in t+2.
  - Written to the FIFO at the edge ending t+2, so `out_valid`/`out_data` appear in cycle t+3 if the FIFO was empty. Total latency is 3 cycles.
- Throughput: one result per cycle, sustained while `out_ready` stays high.
- `count` and `inflight` are registered and update one edge after the push/pop event.
- Reset values (synchronous; applied on any edge with `rst = 1`, including mid-stream):
  - `s1_v`, `s2_v`, `count`, and both pointers = 0.
  - `out_valid` = 0, `out_data` = 0, `inflight` = 0, `overflow` = 0, `range_err` = 0.
  - In-flight data is discarded. The first input sampled after `rst` deasserts behaves exactly as a fresh stream.
- No combinational path from `out_ready` to `out_valid` or `out_data`. A combinational path from `out_ready` to the FIFO write-enable (full with simultaneous pop) is allowed.

## Structure
- Package `PARAMS_BN254_d0` holds:
  - the existing constants `Mod` and `qpmm_fp_t`;
  - new constants `Mod2 = 2·Mod` and `Mod4 = 4·Mod`, each `W` bits wide.
- One sub-module: `fp_fifo_fwft`, parameterised by `WIDTH` and `DEPTH`, with ports:
  - `clk`, `rst`, `wr_en`, `wr_data`;
  - `rd_en`, `rd_data`, `valid`, `count`.
  - It holds the pointers, storage array and occupancy counter.
- The top level holds the S1/S2 subtract-compare datapath, the valid pipeline, the `inflight` counter, the flags and the drop logic.

## Test plan
- Single values, with `out_ready = 1`:
  - `Z = Mod−1` → `Mod−1`.
  - `Z = Mod` → 0.
  - `Z = 2·Mod+5` → 5.
  - `Z = 4·Mod−1` → `Mod−1`.
  - Each appears exactly 3 cycles after issue, and `range_err` stays 0.
- Streaming: 10000 random `Z < 4·Mod` back-to-back with `out_ready = 1` → every output equals `Z mod Mod`, in order, with no gaps after the first 3 cycles.
- Back-pressure: hold `out_ready = 0` and issue `DEPTH+1` consecutive values 1..`DEPTH+1`:
  - `count` reaches `DEPTH`, `overflow` = 1;
  - draining yields 1..`DEPTH` and the value `DEPTH+1` is lost.
- Full with simultaneous pop: fill the FIFO, then issue while `out_ready = 1` → `count` stays `DEPTH`, `overflow` stays 0, and order is preserved.
- Out-of-range input: `Z = 4·Mod` → `range_err` = 1 from cycle t+1, and the output is `Mod` (that is, `4·Mod − 3·Mod`).
- Mid-stream reset: assert `rst` for 1 cycle with 3 entries buffered and 2 in flight → next cycle `count = 0`, `inflight = 0`, `out_valid = 0`, flags 0, and the first post-reset input emerges 3 cycles after issue.
